alu_issue: RTL and testbench
============================

// Module: alu_issue
// PURPOSE
// - Initiator side of the ALU control/operand interface. Accepts decoded RV32I ALU ops (R-type and I-type) over a
//   valid/ready handshake, translates funct3/funct7[5] into the 3-bit ALU control code, and drives the ALU operands.
// - Tracks the ALU's 1-cycle registered latency and returns result + rd over a second valid/ready handshake.
// - Sits between the decode stage and the alu instance in the upduino datapath.
// PARAMETERS
// - WORD_SIZE  32  operand/result width; must match the alu instance.
// PORTS
// - clk          in   1          single clock, posedge
// - reset        in   1          asynchronous, active-low reset
// - in_valid     in   1          op request valid
// - in_ready     out  1          op request accepted when in_valid && in_ready at posedge
// - in_funct3    in   3          RV32I funct3
// - in_funct7_5  in   1          instr[30] (SUB/SRA select; imm[10] for SRAI)
// - in_is_imm    in   1          1 = I-type: operand 2 is in_imm
// - in_rs1       in   WORD_SIZE  operand 1
// - in_rs2       in   WORD_SIZE  operand 2 (R-type)
// - in_imm       in   WORD_SIZE  sign-extended immediate (I-type)
// - in_rd        in   5          destination register tag
// - alu_control  out  3          to alu.control: ADD 000 SUB 001 AND 010 OR 011 XOR 100 SL 101 SRL 110 SRA 111
// - alu_in_1     out  WORD_SIZE  to alu.in_1
// - alu_in_2     out  WORD_SIZE  to alu.in_2
// - alu_out      in   WORD_SIZE  from alu.out (valid 1 cycle after control/operands are presented)
// - out_valid    out  1          result valid
// - out_ready    in   1          result consumed when out_valid && out_ready at posedge
// - out_result   out  WORD_SIZE  = alu_out while out_valid, else 0
// - out_rd       out  5          rd of the op in flight
// - err_illegal  out  1          1-cycle pulse: unsupported funct3 was accepted and dropped
// BEHAVIOUR
// - Reset (async, reset==0): state IDLE; in_ready, out_valid, err_illegal = 0; alu_control = 000;
//   alu_in_1/2, out_result = 0; out_rd = 0. Any op in flight is discarded.
// - FSM: IDLE -> EXEC -> VALID.
//   - IDLE: in_ready = 1. On accept of a legal op: register control, operands and rd; go to EXEC.
//     On accept of an illegal op: err_illegal = 1 in the next cycle; stay in IDLE.
//   - EXEC: in_ready = 0. The registered control/operands drive the ALU, which samples them at the end of this cycle.
//   - VALID: out_valid = 1; out_result = alu_out. Operand/control registers are held stable, so alu_out stays stable.
//     If out_ready = 1: return to IDLE, or go to EXEC if a new op is accepted in the same cycle.
// - in_ready = (IDLE) || (VALID && out_ready). This is combinational from state and out_ready.
// - Latency: accept at edge N -> out_valid high in cycle N+2. Peak throughput is 1 op / 2 cycles with back-to-back
//   acceptance.
// - Decode (funct3):
//   - 000: ADD, or SUB when funct7_5 && !is_imm
//   - 001: SL
//   - 100: XOR
//   - 101: SRL, or SRA when funct7_5
//   - 110: OR
//   - 111: AND
//   - 010, 011 (SLT/SLTU): illegal
// - Operand 2 = is_imm ? in_imm : in_rs2. For SL/SRL/SRA, alu_in_2 = {27'b0, op2[4:0]} (shift amount masked to 5 bits).
// - Arithmetic wraps modulo 2^WORD_SIZE, and no overflow flag is produced.
// - With out_ready held low, out_valid, out_result and out_rd stay held indefinitely and no new op is accepted.
// - Inputs are ignored when not accepted. in_valid may drop without an accept.
// CONFIGURATION
// - ALU_ISSUE_STATS_EN defined: adds outputs stat_ops [31:0] and stat_illegal [31:0].
//   - stat_ops increments on each result handshake; stat_illegal increments on each illegal accept.
//   - Both are free-running, wrap 0xFFFFFFFF -> 0, and reset to 0.
// - ALU_ISSUE_STATS_EN undefined: no counters and no stat ports; all other behaviour is identical.
// TESTING (bench pairs alu_issue with alu; alu reset driven as ~reset)
// - ADD: rs1=5, rs2=7, funct3=000, f7=0, rd=3, accepted at edge N -> out_valid in cycle N+2; result 12; rd 3.
// - SUB/ADDI: rs1=3, rs2=5, f7=1, R-type -> 0xFFFFFFFE. rs1=10, imm=0xFFFFFFFF, f7=1, is_imm -> 9 (ADD, not SUB).
// - Shifts: rs1=0x80000000, rs2=0x24 (amount masked to 4): funct3=101, f7=1 -> 0xF8000000;
//   f7=0 -> 0x08000000; funct3=001 -> 0x00000000.
// - Backpressure: out_ready=0 for 5 cycles -> out_valid, result and rd held, in_ready=0.
//   Then out_ready=1 with in_valid=1 -> result retired and new op accepted on the same edge.
// - Illegal: funct3=010 accepted -> err_illegal high exactly 1 cycle, no out_valid, in_ready=1 the following cycle.
// - Reset mid-op: reset=0 while in EXEC -> out_valid=0 and in_ready=0 immediately (async).
//   After release, IDLE with in_ready=1 and no stale result.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: issue side of the ALU control/operand interface.
// Accepts decoded RV32I ALU ops over valid/ready, drives control/operands to a
// registered ALU (1-cycle latency) and returns result + rd over valid/ready.
// Optional build macro ALU_ISSUE_STATS_EN adds stat_ops / stat_illegal counters.
module alu_issue #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_funct3,
    input  logic                 in_funct7_5,
    input  logic                 in_is_imm,
    input  logic [WORD_SIZE-1:0] in_rs1,
    input  logic [WORD_SIZE-1:0] in_rs2,
    input  logic [WORD_SIZE-1:0] in_imm,
    input  logic [4:0]           in_rd,
    output logic [2:0]           alu_control,
    output logic [WORD_SIZE-1:0] alu_in_1,
    output logic [WORD_SIZE-1:0] alu_in_2,
    input  logic [WORD_SIZE-1:0] alu_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_result,
    output logic [4:0]           out_rd,
    output logic                 err_illegal
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [31:0]          stat_ops,
    output logic [31:0]          stat_illegal
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, VALID} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   accept;
    logic                   legal;
    logic [2:0]             dec_ctrl;
    logic [WORD_SIZE-1:0]   op2;
    logic [WORD_SIZE-1:0]   dec_in2;
    logic [2:0]             ctrl_q;
    logic [WORD_SIZE-1:0]   in1_q;
    logic [WORD_SIZE-1:0]   in2_q;
    logic [4:0]             rd_q;
    logic                   err_q;

    assign accept = in_valid && in_ready;
    assign op2    = in_is_imm ? in_imm : in_rs2;

    // Decode funct3/funct7[5] into the ALU control code and operand 2
    always_comb begin
        legal    = 1'b1;
        dec_ctrl = 3'b000;
        dec_in2  = op2;
        case (in_funct3)
            3'b000: dec_ctrl = (in_funct7_5 && !in_is_imm) ? 3'b001 : 3'b000;
            3'b001: dec_ctrl = 3'b101;
            3'b100: dec_ctrl = 3'b100;
            3'b101: dec_ctrl = in_funct7_5 ? 3'b111 : 3'b110;
            3'b110: dec_ctrl = 3'b011;
            3'b111: dec_ctrl = 3'b010;
            default: legal = 1'b0;
        endcase
        if (dec_ctrl == 3'b101 || dec_ctrl == 3'b110 || dec_ctrl == 3'b111) begin
            dec_in2 = {{(WORD_SIZE-5){1'b0}}, op2[4:0]};
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and in_ready; in_ready is forced low while reset is asserted
    always_comb begin
        in_ready  = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && legal) state_nxt = EXEC;
            end
            EXEC: state_nxt = VALID;
            VALID: begin
                if (out_ready) begin
                    in_ready  = 1'b1;
                    state_nxt = (in_valid && legal) ? EXEC : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!reset) in_ready = 1'b0;
    end

    // Operand/control/rd capture on a legal accept; illegal accept pulses err
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q <= '0;
            in1_q  <= '0;
            in2_q  <= '0;
            rd_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= accept && !legal;
            if (accept && legal) begin
                ctrl_q <= dec_ctrl;
                in1_q  <= in_rs1;
                in2_q  <= dec_in2;
                rd_q   <= in_rd;
            end
        end
    end

    assign alu_control = ctrl_q;
    assign alu_in_1    = in1_q;
    assign alu_in_2    = in2_q;
    assign out_valid   = (state == VALID);
    assign out_result  = out_valid ? alu_out : '0;
    assign out_rd      = rd_q;
    assign err_illegal = err_q;

`ifdef ALU_ISSUE_STATS_EN
    // Free-running result-handshake and illegal-accept counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_ops     <= '0;
            stat_illegal <= '0;
        end else begin
            if (out_valid && out_ready) stat_ops <= stat_ops + 32'd1;
            if (accept && !legal) stat_illegal <= stat_illegal + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: self-checking bench for alu_issue, paired with a behavioural
// registered ALU stand-in. Expected results come from RV32I semantics.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_funct3 = '0;
    logic        in_funct7_5 = 1'b0;
    logic        in_is_imm = 1'b0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic [4:0]  in_rd = '0;
    logic [2:0]  alu_control;
    logic [31:0] alu_in_1;
    logic [31:0] alu_in_2;
    logic [31:0] alu_out;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        err_illegal;
`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] stat_ops;
    logic [31:0] stat_illegal;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    alu_issue #(.WORD_SIZE(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_funct3(in_funct3), .in_funct7_5(in_funct7_5), .in_is_imm(in_is_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_rd(in_rd),
        .alu_control(alu_control), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
        .alu_out(alu_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .err_illegal(err_illegal)
`ifdef ALU_ISSUE_STATS_EN
        , .stat_ops(stat_ops), .stat_illegal(stat_illegal)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the alu instance: result registered one cycle
    function automatic logic [31:0] alu_fn(logic [2:0] c, logic [31:0] a, logic [31:0] b);
        case (c)
            3'b000: return a + b;
            3'b001: return a - b;
            3'b010: return a & b;
            3'b011: return a | b;
            3'b100: return a ^ b;
            3'b101: return a << b[4:0];
            3'b110: return a >> b[4:0];
            default: return $unsigned($signed(a) >>> b[4:0]);
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) alu_out <= '0;
        else        alu_out <= alu_fn(alu_control, alu_in_1, alu_in_2);
    end

    // Reference: RV32I semantics of the op, keyed on funct3
    function automatic logic ref_op(logic [2:0] f3, logic f7, logic im, logic [31:0] rs1,
                                    logic [31:0] rs2, logic [31:0] imm,
                                    output logic [31:0] val, output logic [2:0] code,
                                    output logic [31:0] in2);
        logic [31:0] o2;
        int unsigned sh;
        o2 = im ? imm : rs2;
        sh = o2 % 32;
        in2 = o2;
        val = '0;
        code = '0;
        case (f3)
            3'd0: begin
                if (f7 && !im) begin val = rs1 - o2; code = 3'd1; end
                else begin val = rs1 + o2; code = 3'd0; end
            end
            3'd1: begin val = rs1 << sh; code = 3'd5; in2 = sh; end
            3'd4: begin val = rs1 ^ o2; code = 3'd4; end
            3'd5: begin
                in2 = sh;
                if (f7) begin val = $unsigned($signed(rs1) >>> sh); code = 3'd7; end
                else begin val = rs1 >> sh; code = 3'd6; end
            end
            3'd6: begin val = rs1 | o2; code = 3'd3; end
            3'd7: begin val = rs1 & o2; code = 3'd2; end
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(logic [2:0] f3, logic f7, logic im, logic [31:0] rs1,
                         logic [31:0] rs2, logic [31:0] imm, logic [4:0] rd);
        in_valid = 1'b1;
        in_funct3 = f3; in_funct7_5 = f7; in_is_imm = im;
        in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_rd = rd;
    endtask

    task automatic scramble();
        in_valid = 1'b0;
        in_funct3 = 3'($urandom); in_funct7_5 = 1'($urandom); in_is_imm = 1'($urandom);
        in_rs1 = $urandom; in_rs2 = $urandom; in_imm = $urandom; in_rd = 5'($urandom);
    endtask

    // Issue one op from IDLE (called just after a negedge), stall the result, retire it
    task automatic do_op(string tag, logic [2:0] f3, logic f7, logic im, logic [31:0] rs1,
                         logic [31:0] rs2, logic [31:0] imm, logic [4:0] rd, int stall);
        logic [31:0] ev, ein2;
        logic [2:0]  ecode;
        logic        lg;
        int          k;
        lg = ref_op(f3, f7, im, rs1, rs2, imm, ev, ecode, ein2);
        out_ready = (stall == 0);
        drive(f3, f7, im, rs1, rs2, imm, rd);
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        scramble();
        if (!lg) begin
            chk({tag, ".err"}, 32'(err_illegal), 32'd1);
            chk({tag, ".noval"}, 32'(out_valid), 32'd0);
            chk({tag, ".rdy_after_ill"}, 32'(in_ready), 32'd1);
            @(negedge clk);
            chk({tag, ".err_off"}, 32'(err_illegal), 32'd0);
            chk({tag, ".noval2"}, 32'(out_valid), 32'd0);
            out_ready = 1'b1;
            return;
        end
        chk({tag, ".exec_val"}, 32'(out_valid), 32'd0);
        chk({tag, ".exec_rdy"}, 32'(in_ready), 32'd0);
        chk({tag, ".exec_err"}, 32'(err_illegal), 32'd0);
        chk({tag, ".ctrl"}, 32'(alu_control), 32'(ecode));
        chk({tag, ".in2"}, alu_in_2, ein2);
        @(negedge clk);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".result"}, out_result, ev);
        chk({tag, ".rd"}, 32'(out_rd), 32'(rd));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, ".hold_val"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_res"}, out_result, ev);
            chk({tag, ".hold_rdy"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk({tag, ".ret_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".retired"}, 32'(out_valid), 32'd0);
        chk({tag, ".idle_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] ev, ein2;
        logic [2:0]  ecode;
        logic        lg;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.err", 32'(err_illegal), 32'd0);
        chk("rst.ctrl", 32'(alu_control), 32'd0);
        chk("rst.in1", alu_in_1, 32'd0);
        chk("rst.in2", alu_in_2, 32'd0);
        chk("rst.result", out_result, 32'd0);
        chk("rst.rd", 32'(out_rd), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rel.in_ready", 32'(in_ready), 32'd1);

        // Directed ops
        do_op("add", 3'b000, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 5'd3, 0);
        do_op("sub", 3'b000, 1'b1, 1'b0, 32'd3, 32'd5, 32'd0, 5'd4, 0);
        do_op("addi", 3'b000, 1'b1, 1'b1, 32'd10, 32'd0, 32'hFFFF_FFFF, 5'd5, 1);
        do_op("sra", 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'h24, 32'd0, 5'd6, 0);
        do_op("srl", 3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'h24, 32'd0, 5'd7, 0);
        do_op("sll", 3'b001, 1'b0, 1'b0, 32'h8000_0000, 32'h24, 32'd0, 5'd8, 0);
        do_op("ill", 3'b010, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 5'd9, 0);
        do_op("ill3", 3'b011, 1'b0, 1'b1, 32'd1, 32'd2, 32'd3, 5'd9, 0);

        // Backpressure for 5 cycles, then retire and accept on the same edge
        out_ready = 1'b0;
        drive(3'b000, 1'b0, 1'b0, 32'd100, 32'd23, 32'd0, 5'd17);
        @(posedge clk);
        @(negedge clk);
        scramble();
        @(negedge clk);
        drive(3'b100, 1'b0, 1'b1, 32'h0F0F_00FF, 32'd0, 32'hFFFF_0F0F, 5'd21);
        for (int i = 0; i < 5; i++) begin
            chk("bp.valid", 32'(out_valid), 32'd1);
            chk("bp.result", out_result, 32'd123);
            chk("bp.rd", 32'(out_rd), 32'd17);
            chk("bp.in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.rdy_on_release", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        scramble();
        chk("bp.b2b_exec", 32'(out_valid), 32'd0);
        chk("bp.b2b_ctrl", 32'(alu_control), 32'd4);
        @(negedge clk);
        chk("bp.b2b_valid", 32'(out_valid), 32'd1);
        chk("bp.b2b_result", out_result, 32'hF0F0_0FF0);
        chk("bp.b2b_rd", 32'(out_rd), 32'd21);
        @(posedge clk);
        @(negedge clk);
        chk("bp.idle", 32'(in_ready), 32'd1);

        // Reset while the op is in EXEC
        drive(3'b110, 1'b0, 1'b0, 32'h1234_0000, 32'h0000_5678, 32'd0, 5'd30);
        @(posedge clk);
        @(negedge clk);
        scramble();
        #2 reset = 1'b0;
        #1;
        chk("mrst.out_valid", 32'(out_valid), 32'd0);
        chk("mrst.in_ready", 32'(in_ready), 32'd0);
        chk("mrst.rd", 32'(out_rd), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst.rdy_after", 32'(in_ready), 32'd1);
        chk("mrst.no_valid", 32'(out_valid), 32'd0);
        chk("mrst.no_result", out_result, 32'd0);
        @(negedge clk);
        chk("mrst.no_stale", 32'(out_valid), 32'd0);

        // Randomized ops with random backpressure
        for (int n = 0; n < 150; n++) begin
            logic [2:0]  f3;
            logic        f7, im;
            logic [31:0] a, b, c;
            f3 = 3'($urandom);
            f7 = 1'($urandom);
            im = 1'($urandom);
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            c  = $urandom;
            lg = ref_op(f3, f7, im, a, b, c, ev, ecode, ein2);
            do_op(lg ? "rnd" : "rnd_ill", f3, f7, im, a, b, c, 5'($urandom),
                  int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
